// File: rtl/fifo_uart_tx_pkg.sv
// fifo_uart_pkg: shared types and helpers for the FIFO-to-UART transmit drain.
//   tx_state_t   : frame sequencer states
//   UART_DATA_W  : serial payload width (one FIFO word)
//   even_parity(): parity bit that makes the count of ones in data+parity even
package fifo_uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } tx_state_t;

  function automatic logic even_parity(input logic [UART_DATA_W-1:0] data);
    even_parity = ^data;
  endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// fifo_uart_tx_if: FIFO read side plus serial outputs of the transmit drain.
//   empty, dout      : FIFO status and read data (FIFO -> drain)
//   rd               : FIFO read strobe (drain -> FIFO)
//   tx, busy,
//   frame_done       : serial line and frame status (drain -> downstream)
// master = the drain, slave = the FIFO / line observer.
interface fifo_uart_tx_if;
  import fifo_uart_pkg::*;

  logic                   empty;
  logic [UART_DATA_W-1:0] dout;
  logic                   rd;
  logic                   tx;
  logic                   busy;
  logic                   frame_done;

  modport master (
    input  empty, dout,
    output rd, tx, busy, frame_done
  );

  modport slave (
    output empty, dout,
    input  rd, tx, busy, frame_done
  );

endinterface

// File: rtl/fifo_uart_tx_bit_timer.sv
// uart_bit_timer: free-running bit-period counter.
//   clk_i/rst : clock and synchronous active-high reset (ports clk, rst)
//   clr       : restart the count at 0 in the next cycle
//   tick      : high in the last cycle of a bit period (count == CLKS_PER_BIT-1)
//   pre_tick  : high one cycle before tick, lets the caller register
//               outputs that must coincide with tick
module uart_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 32'd16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick,
  output logic pre_tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 32'd1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 32'd1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 32'd2);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick     = (cnt_q == CNT_LAST);
  assign pre_tick = (cnt_q == CNT_PRE);

  // Next count: clear on request, wrap after the last cycle, else increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = CNT_ZERO;
    end else if (tick) begin
      cnt_d = CNT_ZERO;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= CNT_ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_uart_tx_chk.sv
// fifo_uart_tx_chk: protocol properties of the transmit drain.
//   clk, rst : clock and synchronous reset (checks disabled during reset)
//   empty    : FIFO empty flag
//   rd       : FIFO read strobe
//   busy, tx : drain status and serial line
module fifo_uart_tx_chk (
  input logic clk,
  input logic rst,
  input logic empty,
  input logic rd,
  input logic busy,
  input logic tx
);

  // Never read an empty FIFO.
  a_rd_not_empty: assert property (@(posedge clk) disable iff (rst) rd |-> !empty);

  // A read is always a single-cycle pulse.
  a_rd_pulse: assert property (@(posedge clk) disable iff (rst) rd |=> !rd);

  // Line idles high whenever no frame is in progress.
  a_idle_high: assert property (@(posedge clk) disable iff (rst) !busy |-> tx);

endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains bytes from a synchronous FIFO and serialises each one
// as start bit, 8 data bits LSB first, optional even parity, one stop bit.
//   clk         : clock, all state changes on the rising edge
//   rst         : synchronous active-high reset
//   bus.empty   : FIFO empty flag
//   bus.dout    : FIFO read data, valid the cycle after a read
//   bus.rd      : FIFO read strobe (the only combinational output)
//   bus.tx      : serial line, idles high
//   bus.busy    : high while not IDLE
//   bus.frame_done : one-cycle pulse in the last cycle of the stop bit
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 32'd16,
  parameter bit          PARITY_EN    = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  fifo_uart_tx_if.master  bus
);

  tx_state_t              state_q, state_d;
  logic [UART_DATA_W-1:0] shreg_q, shreg_d;
  logic                   par_q, par_d;
  logic [2:0]             idx_q, idx_d;
  logic                   tx_q, tx_d;
  logic                   busy_q;
  logic                   done_q, done_d;
  logic                   tick_s;
  logic                   pre_tick_s;
  logic                   clr_s;

  // Every state entry restarts the bit period at 0.
  assign clr_s = (state_d != state_q);

  uart_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr_s),
    .tick     (tick_s),
    .pre_tick (pre_tick_s)
  );

  // Reads only from IDLE, so there is at most one read per frame.
  assign bus.rd         = (state_q == IDLE) && !bus.empty && !rst;
  assign bus.tx         = tx_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;

  // Frame sequencer: next state, shift register, parity and bit index.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (!bus.empty) begin
          state_d = FETCH;
        end else begin
          state_d = IDLE;
        end
      end
      FETCH: begin
        shreg_d = bus.dout;
        par_d   = even_parity(bus.dout);
        state_d = START;
      end
      START: begin
        if (tick_s) begin
          idx_d   = 3'd0;
          state_d = DATA;
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (tick_s) begin
          shreg_d = {1'b0, shreg_q[UART_DATA_W-1:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = PARITY_EN ? PARITY : STOP;
          end else begin
            state_d = DATA;
          end
        end else begin
          state_d = DATA;
        end
      end
      PARITY: begin
        if (tick_s) begin
          state_d = STOP;
        end else begin
          state_d = PARITY;
        end
      end
      STOP: begin
        if (tick_s) begin
          state_d = IDLE;
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Line level follows the state being entered so tx lines up with it
  // despite being registered.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      PARITY:  tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
  end

  // frame_done is registered one cycle early so it lands on the stop bit's
  // last cycle.
  always_comb begin
    if ((state_q == STOP) && pre_tick_s) begin
      done_d = 1'b1;
    end else begin
      done_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= {UART_DATA_W{1'b0}};
      par_q   <= 1'b0;
      idx_q   <= 3'd0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: two drains (no parity / even parity), each fed by a
// behavioural FIFO queue; expected line waveforms are built from the frame
// format (start, data LSB first, parity, stop) and checked cycle by cycle.
module tb_fifo_uart_tx;

  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_pend = 1'b1;
  always #5 clk = ~clk;

  fifo_uart_tx_if bus0 ();
  fifo_uart_tx_if bus1 ();

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0)) u_dut0 (
    .clk (clk), .rst (rst), .bus (bus0)
  );
  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1)) u_dut1 (
    .clk (clk), .rst (rst), .bus (bus1)
  );

  fifo_uart_tx_chk u_chk0 (
    .clk (clk), .rst (rst), .empty (bus0.empty), .rd (bus0.rd),
    .busy (bus0.busy), .tx (bus0.tx)
  );
  fifo_uart_tx_chk u_chk1 (
    .clk (clk), .rst (rst), .empty (bus1.empty), .rd (bus1.rd),
    .busy (bus1.busy), .tx (bus1.tx)
  );

  logic [7:0] fq0[$];
  logic [7:0] fq1[$];
  logic [3:0] obs [2];          // {rd, tx, busy, frame_done}
  logic [1:0] rd_seen = 2'b00;
  int         rd_cnt [2];
  int         checks = 0;
  int         errors = 0;

  // One clock: apply reset/FIFO updates after the edge, then sample outputs.
  task automatic cyc();
    @(posedge clk);
    #1;
    rst = rst_pend;
    if (rd_seen[0] && fq0.size() > 0) bus0.dout = fq0.pop_front();
    if (rd_seen[1] && fq1.size() > 0) bus1.dout = fq1.pop_front();
    bus0.empty = (fq0.size() == 0);
    bus1.empty = (fq1.size() == 0);
    #1;
    obs[0] = {bus0.rd, bus0.tx, bus0.busy, bus0.frame_done};
    obs[1] = {bus1.rd, bus1.tx, bus1.busy, bus1.frame_done};
    rd_seen = {bus1.rd, bus0.rd};
    rd_cnt[0] += int'(bus0.rd);
    rd_cnt[1] += int'(bus1.rd);
  endtask

  task automatic chk(input int s, input logic [3:0] exp, input string tag);
    checks++;
    assert (obs[s] === exp) else begin
      errors++;
      $error("FAIL %s dut%0d rd/tx/busy/done observed %b expected %b", tag, s, obs[s], exp);
    end
  endtask

  task automatic chk_int(input int got, input int exp, input string tag);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Walks one whole frame of byte b (already queued in the FIFO of dut s).
  // With abort set, reset is raised during data bit 3 and the task returns.
  task automatic run_frame(input int s, input logic [7:0] b, input bit abort,
                           input string tag, output logic par_obs);
    logic [10:0] bits;
    logic [7:0]  rx;
    int          nbits;
    int          ones;
    int          done_at;
    ones = 0;
    for (int k = 0; k < 8; k++) ones += int'(b[k]);
    nbits = (s == 1) ? 11 : 10;
    bits = 11'd0;
    for (int k = 0; k < 8; k++) bits[k+1] = b[k];
    if (s == 1) bits[9] = ((ones % 2) == 1);
    bits[nbits-1] = 1'b1;
    rx = 8'h00;
    par_obs = 1'b0;
    done_at = -1;
    cyc(); chk(s, 4'b1100, {tag, "_idle_rd"});
    cyc(); chk(s, 4'b0110, {tag, "_fetch"});
    for (int i = 0; i < nbits; i++) begin
      for (int c = 0; c < CPB; c++) begin
        cyc();
        chk(s, {1'b0, bits[i], 1'b1, (i == nbits - 1) && (c == CPB - 1)}, {tag, "_bit"});
        if (c == CPB / 2 && i >= 1 && i <= 8) rx[i-1] = obs[s][2];
        if (c == CPB / 2 && i == 9 && s == 1) par_obs = obs[s][2];
        if (obs[s][0]) done_at = i * CPB + c + 1;
        if (abort && i == 4 && c == 1) begin
          rst_pend = 1'b1;
          cyc(); chk(s, {1'b0, bits[4], 1'b1, 1'b0}, {tag, "_rst_in"});
          cyc(); chk(s, 4'b0100, {tag, "_rst_out"});
          rst_pend = 1'b0;
          return;
        end
      end
    end
    chk_int(int'(rx), int'(b), {tag, "_decoded"});
    chk_int(done_at, nbits * CPB, {tag, "_done_cycle"});
  endtask

  initial begin
    logic [7:0] vals [8];
    logic       p;
    int         base;
    rd_cnt[0] = 0;
    rd_cnt[1] = 0;
    bus0.empty = 1'b1; bus0.dout = 8'h00;
    bus1.empty = 1'b1; bus1.dout = 8'h00;

    // Reset state.
    for (int k = 0; k < 3; k++) begin
      cyc(); chk(0, 4'b0100, "reset"); chk(1, 4'b0100, "reset");
    end
    rst_pend = 1'b0;

    // Empty guard.
    for (int k = 0; k < 100; k++) begin
      cyc(); chk(0, 4'b0100, "empty_guard"); chk(1, 4'b0100, "empty_guard");
    end

    // Single byte 0xA5.
    base = rd_cnt[0];
    fq0.push_back(8'hA5);
    run_frame(0, 8'hA5, 1'b0, "single", p);
    for (int k = 0; k < 3; k++) begin
      cyc(); chk(0, 4'b0100, "single_after");
    end
    chk_int(rd_cnt[0] - base, 1, "single_rd_count");

    // Full drain of 16 bytes, back to back.
    base = rd_cnt[0];
    for (int k = 0; k < 16; k++) fq0.push_back(8'(k));
    for (int k = 0; k < 16; k++) run_frame(0, 8'(k), 1'b0, "drain", p);
    cyc(); chk(0, 4'b0100, "drain_after");
    chk_int(int'(bus0.empty), 1, "drain_empty");
    chk_int(rd_cnt[0] - base, 16, "drain_rd_count");

    // Random bytes.
    for (int k = 0; k < 6; k++) begin
      vals[k] = 8'($urandom);
      fq0.push_back(vals[k]);
    end
    for (int k = 0; k < 6; k++) run_frame(0, vals[k], 1'b0, "random", p);

    // Parity variant.
    fq1.push_back(8'h07);
    fq1.push_back(8'h03);
    run_frame(1, 8'h07, 1'b0, "parity07", p);
    chk_int(int'(p), 1, "parity07_bit");
    run_frame(1, 8'h03, 1'b0, "parity03", p);
    chk_int(int'(p), 0, "parity03_bit");
    for (int k = 0; k < 4; k++) begin
      vals[k] = 8'($urandom);
      fq1.push_back(vals[k]);
    end
    for (int k = 0; k < 4; k++) run_frame(1, vals[k], 1'b0, "parity_rand", p);
    cyc(); chk(1, 4'b0100, "parity_after");

    // Reset during data bit 3; the next byte must go out complete.
    base = rd_cnt[0];
    vals[0] = 8'($urandom);
    vals[1] = 8'($urandom);
    fq0.push_back(vals[0]);
    fq0.push_back(vals[1]);
    run_frame(0, vals[0], 1'b1, "abort", p);
    run_frame(0, vals[1], 1'b0, "after_abort", p);
    for (int k = 0; k < 3; k++) begin
      cyc(); chk(0, 4'b0100, "final_idle");
    end
    chk_int(rd_cnt[0] - base, 2, "abort_rd_count");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Serial transmit drain for the 8-bit, 16-deep synchronous FIFO. It sits directly downstream of the FIFO, driving the FIFO's `rd` and consuming its `dout`/`empty`. Each byte pulled from the FIFO is serialised onto a single UART line: start bit, 8 data bits LSB first, optional even parity, then one stop bit. All logic runs on the same clock and reset as the FIFO.

## Interface
Parameters:
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; legal range is ≥2.
- `PARITY_EN`, 0: 1 inserts an even-parity bit after data bit 7.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `empty`, in, 1: FIFO empty flag.
- `dout`, in, 8: FIFO read data; valid in the cycle after a `rd` cycle with `!empty`.
- `rd`, out, 1: FIFO read strobe; a one-cycle pulse per byte.
- `tx`, out, 1: serial line; idles high.
- `busy`, out, 1: high whenever the state is not IDLE.
- `frame_done`, out, 1: one-cycle pulse in the last cycle of the stop bit.

## Operation
- States:
  - IDLE → FETCH → START → DATA → (PARITY if `PARITY_EN`) → STOP → IDLE.
- IDLE:
  - `rd = !empty && !rst` (combinational).
  - If `!empty`, go to FETCH next cycle.
  - Never assert `rd` while `empty=1`.
- FETCH:
  - Load an 8-bit shift register from `dout`.
  - Load the parity register with the XOR of `dout`.
  - Go to START.
- START:
  - `tx=0` for `CLKS_PER_BIT` cycles.
- DATA:
  - `tx = shreg[0]` for `CLKS_PER_BIT` cycles per bit.
  - Shift right at the end of each bit.
  - A 3-bit index counts 0..7; leave the state after index 7.
- PARITY:
  - `tx` = parity register (even parity) for `CLKS_PER_BIT` cycles.
- STOP:
  - `tx=1` for `CLKS_PER_BIT` cycles.
  - `frame_done` pulses in the final cycle.
  - Then go to IDLE.
- Bit timer:
  - `$clog2(CLKS_PER_BIT)` bits wide.
  - Cleared on every state entry.
  - Counts 0..CLKS_PER_BIT-1, then wraps with a tick.
- `tx` is registered (one flop); `rd` is the only combinational output.

## Timing
- Reset values: `tx=1`, `rd=0`, `busy=0`, `frame_done=0`, state IDLE, all counters 0.
- Latency, measured from IDLE cycle T with `empty=0`:
  - `rd=1` in T.
  - FETCH in T+1.
  - `tx=0` from T+2.
- Frame length is `(10+PARITY_EN)*CLKS_PER_BIT` cycles of START..STOP.
- Back-to-back bytes:
  - After STOP, one IDLE cycle (with `rd`) and one FETCH cycle hold `tx=1`.
  - The inter-frame gap is therefore exactly 2 extra high cycles.
- `empty` rising while a frame is in flight has no effect; the frame completes and the block then idles.
- `empty` falling in IDLE is acted on in the same cycle.
- Reset mid-frame:
  - Next cycle `tx=1`, state IDLE.
  - The in-flight byte is dropped; it is not re-read.
  - No `rd` while `rst=1`.
- `rd` is never high outside IDLE, so there is at most one read per frame.

## Structure
- Package `fifo_uart_pkg` holds:
  - the `tx_state_t` enum (IDLE, FETCH, START, DATA, PARITY, STOP);
  - the `UART_DATA_W = 8` constant;
  - the `even_parity()` function.
- One sub-module, `uart_bit_timer`:
  - parameter `CLKS_PER_BIT`;
  - inputs `clk`, `rst`, `clr`;
  - output `tick`.
- The top level instantiates `uart_bit_timer` alongside `Syn_FIFO` in the integration bench.

## Test plan
- **Single byte.** `CLKS_PER_BIT=4`; write 0xA5 to the FIFO.
  - One `rd` pulse.
  - `tx` = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles.
  - `frame_done` in cycle 40 of the frame.
  - `busy` low afterwards.
- **Full drain.** Fill the FIFO with 16 bytes 0x00..0x0F.
  - Exactly 16 `rd` pulses.
  - Frames are separated by exactly 2 high cycles.
  - `empty` rises after the 16th `rd`.
  - Decoded bytes match in order.
- **Parity.** `PARITY_EN=1`; send byte 0x07.
  - Parity bit is 1.
  - Frame is 11 bit-times.
  - Byte 0x03 gives parity 0.
- **Empty guard.** Hold `empty=1` for 100 cycles.
  - `rd` is never asserted.
  - `tx` stays 1 and `busy` stays 0.
- **Reset mid-frame.** Assert `rst` during data bit 3.
  - Next cycle `tx=1`, `busy=0`, no `rd`.
  - After release, the next FIFO byte is sent complete.
- **Assertions.**
  - `rd |-> !empty`.
  - `rd |=> !rd`.
  - `!busy |-> tx`.
